// File: rtl/seg_pkg.sv
// Segment patterns and small helpers shared by the 7-segment scanner.
// Patterns are active-low cathode drives, bit6 = a .. bit0 = g.
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b1100000;
   localparam seg_t SEG_C     = 7'b0110001;
   localparam seg_t SEG_D     = 7'b1000010;
   localparam seg_t SEG_E     = 7'b0110000;
   localparam seg_t SEG_F     = 7'b0111000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Ceiling log2, returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment decoder.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_en,
   input  logic       blank,
   output logic [6:0] seg
);

   // Map code to pattern; blank and out-of-range codes turn every segment off.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
            4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
            4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
            4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
            4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
            4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadow
// registers, guard slot, leading-zero blanking and registered outputs.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned GUARD_CYC     = 2,
   parameter int unsigned HEX_MODE      = 0,
   parameter int unsigned BLANK_LEADING = 1,
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1,
   localparam int unsigned DIV_W = clog2(REFRESH_DIV)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    enable,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              cathode,
   output logic                    dp,
   output logic [IDX_W-1:0]        digit_idx
);

   logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              cathode_q, cathode_d;
   logic                    dp_q, dp_d;

   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              cur_code;
   logic                    cur_blank;
   logic                    cur_dp;
   logic                    guard;
   logic [6:0]              seg_w;

   // Shadow registers capture the incoming word on the load strobe.
   always_comb begin
      shadow_digits_d = shadow_digits_q;
      shadow_dp_d     = shadow_dp_q;
      if (load) begin
         shadow_digits_d = digits_in;
         shadow_dp_d     = dp_in;
      end
   end

   // Refresh divider; digit index steps on each divider wrap.
   always_comb begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
         div_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Leading-zero mask: scan from the top digit down while every digit seen is zero.
   always_comb begin
      int unsigned i;
      logic        zero_above;
      zero_above = 1'b1;
      blank_mask = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         i          = NUM_DIGITS - 1 - j;
         zero_above = zero_above & (shadow_digits_q[i*4 +: 4] == 4'h0);
         blank_mask[i] = (BLANK_LEADING != 0) && zero_above && (i != 0);
      end
   end

   // Select the digit currently in its slot.
   always_comb begin
      cur_code  = shadow_digits_q[{idx_q, 2'b00} +: 4];
      cur_blank = blank_mask[idx_q];
      cur_dp    = shadow_dp_q[idx_q];
   end

   seg7_decode u_decode (
      .code   (cur_code),
      .hex_en (HEX_MODE != 0),
      .blank  (cur_blank),
      .seg    (seg_w)
   );

   // Next output values; anode stays dark during the guard window or when disabled.
   always_comb begin
      guard     = (32'(div_q) < GUARD_CYC);
      anode_d   = '1;
      if (enable && !guard) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) anode_d[i] = 1'b0;
         end
      end
      cathode_d = seg_w;
      dp_d      = ~cur_dp;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_digits_q <= '0;
         shadow_dp_q     <= '0;
         div_q           <= '0;
         idx_q           <= '0;
         anode_q         <= '1;
         cathode_q       <= SEG_BLANK;
         dp_q            <= 1'b1;
      end else begin
         shadow_digits_q <= shadow_digits_d;
         shadow_dp_q     <= shadow_dp_d;
         div_q           <= div_d;
         idx_q           <= idx_d;
         anode_q         <= anode_d;
         cathode_q       <= cathode_d;
         dp_q            <= dp_d;
      end
   end

   assign anode     = anode_q;
   assign cathode   = cathode_q;
   assign dp        = dp_q;
   assign digit_idx = idx_q;

endmodule
